align_port_arb: RTL

- Two-requester front end for the align memory core.
- After reset it sequences a zero-fill of all NUMADDR words.
- It then round-robin arbitrates requesters A and B onto the core's single read/write port, one op per cycle.
- It tracks in-flight reads with a tag pipeline and routes each read result back to the requester that issued it.

---
 rtl/align_arb_pkg.sv | 21 ++
 rtl/align_port_arb_if.sv | 63 ++++++
 rtl/align_rd_tag_pipe.sv | 29 ++
 rtl/align_port_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/align_arb_pkg.sv
// Shared types for the align memory two-port front end:
// port ids, FSM states and the in-flight read tag.
package align_arb_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic  vld;
    port_t port;
    logic  oor;
  } tag_t;

endpackage

// File: rtl/align_port_arb_if.sv
// Requester A/B handshakes plus the single core port,
// bundled for the align front end.
interface align_port_arb_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 10,
  parameter int BITPADR = 10
);

  logic               a_vld;
  logic               a_rdy;
  logic               a_wr;
  logic [BITADDR-1:0] a_addr;
  logic [WIDTH-1:0]   a_din;
  logic               a_rvld;
  logic [WIDTH-1:0]   a_dout;
  logic               a_serr;
  logic [BITPADR-1:0] a_padr;
  logic               a_oor;

  logic               b_vld;
  logic               b_rdy;
  logic               b_wr;
  logic [BITADDR-1:0] b_addr;
  logic [WIDTH-1:0]   b_din;
  logic               b_rvld;
  logic [WIDTH-1:0]   b_dout;
  logic               b_serr;
  logic [BITPADR-1:0] b_padr;
  logic               b_oor;

  logic               core_read;
  logic               core_write;
  logic [BITADDR-1:0] core_addr;
  logic [WIDTH-1:0]   core_din;
  logic [WIDTH-1:0]   core_dout;
  logic               core_serr;
  logic [BITPADR-1:0] core_padr;

  modport slave (
    input  a_vld, a_wr, a_addr, a_din,
    output a_rdy, a_rvld, a_dout,
    output a_serr, a_padr, a_oor,
    input  b_vld, b_wr, b_addr, b_din,
    output b_rdy, b_rvld, b_dout,
    output b_serr, b_padr, b_oor,
    output core_read, core_write,
    output core_addr, core_din,
    input  core_dout, core_serr, core_padr
  );

  modport master (
    output a_vld, a_wr, a_addr, a_din,
    input  a_rdy, a_rvld, a_dout,
    input  a_serr, a_padr, a_oor,
    output b_vld, b_wr, b_addr, b_din,
    input  b_rdy, b_rvld, b_dout,
    input  b_serr, b_padr, b_oor,
    input  core_read, core_write,
    input  core_addr, core_din,
    output core_dout, core_serr, core_padr
  );

endinterface

// File: rtl/align_rd_tag_pipe.sv
// Shift register of read tags; the head lines up with the
// core's read data RD_DELAY cycles after issue.
module align_rd_tag_pipe
  import align_arb_pkg::*;
#(
  parameter int RD_DELAY = 3
) (
  input  logic clk,
  input  logic clr,
  input  tag_t din,
  output tag_t head
);

  tag_t stg [RD_DELAY];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_DELAY; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < RD_DELAY; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign head = stg[RD_DELAY-1];

endmodule

// File: rtl/align_port_arb.sv
// Zero-fills the align core after reset, then round-robins
// requesters A and B onto its single port and routes reads back.
module align_port_arb
  import align_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUMADDR  = 1024,
  parameter int BITADDR  = 10,
  parameter int BITPADR  = 10,
  parameter int RD_DELAY = 3
) (
  input  logic clk,
  input  logic rst,
  output logic init_done,
  align_port_arb_if.slave bus
);

  localparam logic [BITADDR-1:0] LAST =
    BITADDR'(NUMADDR - 1);

  state_t             state_q;
  state_t             state_d;
  logic [BITADDR-1:0] cnt_q;
  port_t              rr_q;

  logic               run;
  logic               a_acc;
  logic               b_acc;
  logic               acc;
  logic               op_wr;
  logic [BITADDR-1:0] op_addr;
  logic [WIDTH-1:0]   op_din;
  logic               op_oor;
  tag_t               tag_in;
  tag_t               head;
  logic               a_hit;
  logic               b_hit;

  // Ties go to whichever port did not win last time.
  always_comb begin
    run   = (state_q == RUN) && !rst;
    a_acc = run && bus.a_vld &&
            (!bus.b_vld || rr_q == PORT_B);
    b_acc = run && bus.b_vld &&
            (!bus.a_vld || rr_q == PORT_A);
    acc   = a_acc || b_acc;
    bus.a_rdy = a_acc;
    bus.b_rdy = b_acc;
    op_wr   = b_acc ? bus.b_wr   : bus.a_wr;
    op_addr = b_acc ? bus.b_addr : bus.a_addr;
    op_din  = b_acc ? bus.b_din  : bus.a_din;
    op_oor  = 32'(op_addr) >= 32'(NUMADDR);
  end

  always_comb begin
    state_d        = state_q;
    init_done      = 1'b0;
    bus.core_read  = 1'b0;
    bus.core_write = 1'b0;
    bus.core_addr  = '0;
    bus.core_din   = '0;
    unique case (state_q)
      INIT: begin
        if (!rst) begin
          bus.core_write = 1'b1;
          bus.core_addr  = cnt_q;
          if (cnt_q == LAST)
            state_d = RUN;
        end
      end
      RUN: begin
        init_done = !rst;
        if (acc) begin
          bus.core_read  = !op_wr && !op_oor;
          bus.core_write = op_wr && !op_oor;
          bus.core_addr  = op_addr;
          bus.core_din   = op_din;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= INIT;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q == INIT)
      cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_q <= PORT_B;
    else if (acc)
      rr_q <= b_acc ? PORT_B : PORT_A;
  end

  // Out-of-range reads still take a slot to keep ordering.
  always_comb begin
    tag_in.vld  = acc && !op_wr;
    tag_in.port = b_acc ? PORT_B : PORT_A;
    tag_in.oor  = op_oor;
  end

  align_rd_tag_pipe #(
    .RD_DELAY (RD_DELAY)
  ) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in),
    .head (head)
  );

  always_comb begin
    a_hit = !rst && head.vld && head.port == PORT_A;
    b_hit = !rst && head.vld && head.port == PORT_B;
    bus.a_rvld = a_hit;
    bus.b_rvld = b_hit;
    bus.a_oor  = a_hit && head.oor;
    bus.b_oor  = b_hit && head.oor;
    bus.a_dout = '0;
    bus.a_serr = 1'b0;
    bus.a_padr = '0;
    bus.b_dout = '0;
    bus.b_serr = 1'b0;
    bus.b_padr = '0;
    if (a_hit && !head.oor) begin
      bus.a_dout = bus.core_dout;
      bus.a_serr = bus.core_serr;
      bus.a_padr = bus.core_padr;
    end
    if (b_hit && !head.oor) begin
      bus.b_dout = bus.core_dout;
      bus.b_serr = bus.core_serr;
      bus.b_padr = bus.core_padr;
    end
  end

endmodule
